// File: rtl/gold_ring_pkg.sv
// Shared ring definitions: packet layout and virtual-channel encoding.
// Packets use [0:DATA_W-1] ordering, so bit 0 is the MSB.
package gold_ring_pkg;

  localparam int DATA_W = 64;
  localparam int VC_BIT = 0;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  typedef logic [0:DATA_W-1] packet_t;

endpackage

// File: rtl/gold_local_port_if.sv
// NIC-facing and ring-facing handshake bundle of the local port.
// slave = the port itself, master = the NIC/ring environment around it.
interface gold_local_port_if;
  import gold_ring_pkg::*;

  logic    net_polarity;
  logic    net_si;
  logic    net_ri;
  packet_t net_di;
  logic    net_so;
  logic    net_ro;
  packet_t net_do;
  logic    ring_si;
  logic    ring_ri;
  packet_t ring_di;
  logic    ring_so;
  logic    ring_ro;
  packet_t ring_do;

  modport slave (
    output net_polarity, net_si, net_di, net_ro, ring_ri, ring_so, ring_do,
    input  net_ri, net_so, net_do, ring_si, ring_di, ring_ro
  );

  modport master (
    input  net_polarity, net_si, net_di, net_ro, ring_ri, ring_so, ring_do,
    output net_ri, net_so, net_do, ring_si, ring_di, ring_ro
  );

endinterface

// File: rtl/gold_vc_slot.sv
// One-entry packet buffer with fill/drain strobes. Fill wins over drain;
// the top never strobes both on the same slot in one cycle.
module gold_vc_slot
  import gold_ring_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    fill,
  input  logic    drain,
  input  packet_t din,
  output logic    full,
  output packet_t dout
);

  logic    full_r;
  packet_t buf_r;

  // Slot occupancy and payload; data stays put until the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      buf_r  <= {DATA_W{1'b0}};
    end else if (fill) begin
      full_r <= 1'b1;
      buf_r  <= din;
    end else if (drain) begin
      full_r <= 1'b0;
      buf_r  <= buf_r;
    end else begin
      full_r <= full_r;
      buf_r  <= buf_r;
    end
  end

  assign full = full_r;
  assign dout = buf_r;

endmodule

// File: rtl/gold_local_port.sv
// Router-side local port: per-VC injection/ejection slots steered by a toggling polarity.
// Optional statistics counters are enabled with GOLD_LOCAL_PORT_STATS_EN.
module gold_local_port
  import gold_ring_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  gold_local_port_if.slave   lp,
  output logic [CNT_W-1:0]   inj_count,
  output logic [CNT_W-1:0]   ej_count
);

  logic       polarity_r;
  logic       nic_vc_s;
  logic       ring_vc_s;
  logic [1:0] inj_full_s;
  logic [1:0] ej_full_s;
  logic [1:0] inj_fill_s;
  logic [1:0] inj_drain_s;
  logic [1:0] ej_fill_s;
  logic [1:0] ej_drain_s;
  packet_t    inj_buf_s [2];
  packet_t    ej_buf_s  [2];
  logic       net_accept_s;
  logic       ring_send_s;
  logic       ring_accept_s;
  logic       net_deliver_s;

  // Polarity alternates every cycle and restarts at even after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_r <= 1'b0;
    end else begin
      polarity_r <= ~polarity_r;
    end
  end

  // NIC side owns the slots of VC != polarity, ring side the slots of VC == polarity.
  always_comb begin
    nic_vc_s      = ~polarity_r;
    ring_vc_s     = polarity_r;
    net_accept_s  = reset & lp.net_so  & ~inj_full_s[nic_vc_s];
    ring_send_s   = reset & lp.ring_ro &  inj_full_s[ring_vc_s];
    ring_accept_s = reset & lp.ring_si & ~ej_full_s[ring_vc_s];
    net_deliver_s = reset & lp.net_ri  &  ej_full_s[nic_vc_s];
    inj_fill_s    = 2'b00;
    inj_drain_s   = 2'b00;
    ej_fill_s     = 2'b00;
    ej_drain_s    = 2'b00;
    inj_fill_s[nic_vc_s]   = net_accept_s;
    inj_drain_s[ring_vc_s] = ring_send_s;
    ej_fill_s[ring_vc_s]   = ring_accept_s;
    ej_drain_s[nic_vc_s]   = net_deliver_s;
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    gold_vc_slot u_inj (
      .clk   (clk),
      .rst_n (reset),
      .fill  (inj_fill_s[v]),
      .drain (inj_drain_s[v]),
      .din   (lp.net_do),
      .full  (inj_full_s[v]),
      .dout  (inj_buf_s[v])
    );

    gold_vc_slot u_ej (
      .clk   (clk),
      .rst_n (reset),
      .fill  (ej_fill_s[v]),
      .drain (ej_drain_s[v]),
      .din   (lp.ring_di),
      .full  (ej_full_s[v]),
      .dout  (ej_buf_s[v])
    );
  end

  // Handshake and data outputs are forced quiet while reset is held.
  always_comb begin
    lp.net_polarity = polarity_r;
    if (reset) begin
      lp.net_ro  = ~inj_full_s[nic_vc_s];
      lp.ring_so = inj_full_s[ring_vc_s];
      lp.ring_do = inj_buf_s[ring_vc_s];
      lp.ring_ri = ~ej_full_s[ring_vc_s];
      lp.net_si  = ej_full_s[nic_vc_s];
      lp.net_di  = ej_buf_s[nic_vc_s];
    end else begin
      lp.net_ro  = 1'b0;
      lp.ring_so = 1'b0;
      lp.ring_do = {DATA_W{1'b0}};
      lp.ring_ri = 1'b0;
      lp.net_si  = 1'b0;
      lp.net_di  = {DATA_W{1'b0}};
    end
  end

`ifdef GOLD_LOCAL_PORT_STATS_EN
  logic [CNT_W-1:0] inj_cnt_r;
  logic [CNT_W-1:0] ej_cnt_r;

  // Accept/delivery counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_cnt_r <= {CNT_W{1'b0}};
      ej_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      inj_cnt_r <= inj_cnt_r + {{(CNT_W-1){1'b0}}, net_accept_s};
      ej_cnt_r  <= ej_cnt_r  + {{(CNT_W-1){1'b0}}, net_deliver_s};
    end
  end

  assign inj_count = inj_cnt_r;
  assign ej_count  = ej_cnt_r;
`else
  assign inj_count = {CNT_W{1'b0}};
  assign ej_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_gold_local_port.sv
// Self-checking bench for gold_local_port: directed vector table, reset and
// counter-wrap sequences, then random traffic against a slot-level reference model.
module tb_gold_local_port;
  import gold_ring_pkg::*;

  localparam int CNT_W = 4;
`ifdef GOLD_LOCAL_PORT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gold_local_port_if bus();
  logic [CNT_W-1:0] inj_count;
  logic [CNT_W-1:0] ej_count;

  gold_local_port #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .lp        (bus.slave),
    .inj_count (inj_count),
    .ej_count  (ej_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: two slots per direction, indexed by VC.
  bit      m_pol;
  bit      m_inj_full [2];
  bit      m_ej_full  [2];
  packet_t m_inj_buf  [2];
  packet_t m_ej_buf   [2];
  int      m_inj_cnt;
  int      m_ej_cnt;

  typedef struct {
    logic    net_so;  packet_t net_do;
    logic    ring_si; packet_t ring_di;
    logic    net_ri;  logic    ring_ro;
    logic    e_pol;   logic    e_net_ro; logic e_ring_ri;
    logic    e_net_si; logic   e_ring_so;
    packet_t e_net_di; packet_t e_ring_do;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pol = 1'b0;
    for (int v = 0; v < 2; v++) begin
      m_inj_full[v] = 1'b0; m_ej_full[v] = 1'b0;
      m_inj_buf[v]  = '0;   m_ej_buf[v]  = '0;
    end
    m_inj_cnt = 0;
    m_ej_cnt  = 0;
  endtask

  task automatic model_step();
    int n, r;
    bit acc, snd, rac, dlv;
    if (!reset) begin
      model_reset();
      return;
    end
    n = m_pol ? 0 : 1;
    r = m_pol ? 1 : 0;
    acc = bus.net_so  && !m_inj_full[n];
    snd = bus.ring_ro &&  m_inj_full[r];
    rac = bus.ring_si && !m_ej_full[r];
    dlv = bus.net_ri  &&  m_ej_full[n];
    if (acc) begin m_inj_full[n] = 1'b1; m_inj_buf[n] = bus.net_do; m_inj_cnt = (m_inj_cnt + 1) % 16; end
    if (snd) m_inj_full[r] = 1'b0;
    if (rac) begin m_ej_full[r] = 1'b1; m_ej_buf[r] = bus.ring_di; end
    if (dlv) begin m_ej_full[n] = 1'b0; m_ej_cnt = (m_ej_cnt + 1) % 16; end
    m_pol = ~m_pol;
  endtask

  task automatic check_model(input string tag);
    int n, r;
    bit live;
    live = reset;
    n = m_pol ? 0 : 1;
    r = m_pol ? 1 : 0;
    chk({tag, ".pol"},     bus.net_polarity, m_pol);
    chk({tag, ".net_ro"},  bus.net_ro,  live && !m_inj_full[n]);
    chk({tag, ".ring_so"}, bus.ring_so, live &&  m_inj_full[r]);
    chk({tag, ".ring_do"}, bus.ring_do, live ? m_inj_buf[r] : 64'h0);
    chk({tag, ".ring_ri"}, bus.ring_ri, live && !m_ej_full[r]);
    chk({tag, ".net_si"},  bus.net_si,  live &&  m_ej_full[n]);
    chk({tag, ".net_di"},  bus.net_di,  live ? m_ej_buf[n] : 64'h0);
    chk({tag, ".inj_cnt"}, inj_count, STATS ? m_inj_cnt : 0);
    chk({tag, ".ej_cnt"},  ej_count,  STATS ? m_ej_cnt  : 0);
  endtask

  task automatic drive(input logic nso, input packet_t ndo, input logic rsi, input packet_t rdi,
                       input logic nri, input logic rro);
    bus.net_so = nso; bus.net_do = ndo; bus.ring_si = rsi; bus.ring_di = rdi;
    bus.net_ri = nri; bus.ring_ro = rro;
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_random();
    packet_t p, q;
    p = {$urandom(), $urandom()};
    q = {$urandom(), $urandom()};
    p[VC_BIT] = ~m_pol;
    q[VC_BIT] = m_pol;
    drive(1'($urandom_range(1)), p, 1'($urandom_range(1)), q,
          1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  initial begin
    packet_t za, pa, pb, pc, pd, pe, pf;
    za = 64'h0;
    pa = 64'h8000_0000_0000_00AA; pb = 64'h0000_0000_0000_0055;
    pc = 64'h8000_0000_0000_00CC; pd = 64'h0000_0000_0000_00DD;
    pe = 64'h0000_0000_0000_00EE; pf = 64'h8000_0000_0000_00FF;
    // inputs                              | pol ro ri si so | net_di ring_do
    tbl[0]  = '{1'b1, pa, 1'b1, pb, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, za, za};
    tbl[1]  = '{1'b0, za, 1'b0, za, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pb, pa};
    tbl[2]  = '{1'b0, za, 1'b0, za, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, za, za};
    tbl[3]  = '{1'b0, za, 1'b0, za, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, pb, pa};
    tbl[4]  = '{1'b1, pa, 1'b0, za, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, za, za};
    tbl[5]  = '{1'b0, za, 1'b0, za, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pb, pa};
    tbl[6]  = '{1'b1, pc, 1'b0, za, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, za, za};
    tbl[7]  = '{1'b0, za, 1'b0, za, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, pb, pa};
    tbl[8]  = '{1'b1, pc, 1'b1, pd, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, za, za};
    tbl[9]  = '{1'b1, pe, 1'b1, pf, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pd, pc};
    tbl[10] = '{1'b0, za, 1'b0, za, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, pf, pe};
    tbl[11] = '{1'b0, za, 1'b0, za, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, pd, pc};

    drive(1'b0, za, 1'b0, za, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed table: latency, hold under back-pressure, full-slot stall, four-way transfer.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].net_so, tbl[i].net_do, tbl[i].ring_si, tbl[i].ring_di,
            tbl[i].net_ri, tbl[i].ring_ro);
      #1;
      chk($sformatf("row%0d.pol", i),     bus.net_polarity, tbl[i].e_pol);
      chk($sformatf("row%0d.net_ro", i),  bus.net_ro,  tbl[i].e_net_ro);
      chk($sformatf("row%0d.ring_ri", i), bus.ring_ri, tbl[i].e_ring_ri);
      chk($sformatf("row%0d.net_si", i),  bus.net_si,  tbl[i].e_net_si);
      chk($sformatf("row%0d.ring_so", i), bus.ring_so, tbl[i].e_ring_so);
      chk($sformatf("row%0d.net_di", i),  bus.net_di,  tbl[i].e_net_di);
      chk($sformatf("row%0d.ring_do", i), bus.ring_do, tbl[i].e_ring_do);
      check_model($sformatf("row%0d", i));
      advance();
    end

    // Reset held low for three cycles in the middle of traffic.
    for (int i = 0; i < 6; i++) begin
      drive_random(); #1; check_model("pre_rst"); advance();
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_random(); #1;
      chk("rst.net_ro", bus.net_ro, 1'b0);
      chk("rst.ring_ri", bus.ring_ri, 1'b0);
      chk("rst.net_si", bus.net_si, 1'b0);
      chk("rst.ring_so", bus.ring_so, 1'b0);
      check_model("rst");
      advance();
    end
    reset = 1'b1;
    drive(1'b0, za, 1'b0, za, 1'b0, 1'b0);
    #1;
    chk("post_rst.pol", bus.net_polarity, 1'b0);
    chk("post_rst.net_ro", bus.net_ro, 1'b1);
    chk("post_rst.ring_ri", bus.ring_ri, 1'b1);
    chk("post_rst.net_si", bus.net_si, 1'b0);
    chk("post_rst.ring_so", bus.ring_so, 1'b0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive_random(); #1; check_model("rand"); advance();
    end

    // Counter wrap: 17 NIC accepts with the ring always draining.
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, {$urandom(), $urandom()}, 1'b0, za, 1'b0, 1'b1);
      #1; check_model("wrap"); advance();
    end
    drive(1'b0, za, 1'b0, za, 1'b0, 1'b0);
    #1;
    chk("wrap.inj_count", inj_count, STATS ? 4'd1 : 4'd0);
    check_model("wrap_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
